// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution sequencer: state encoding and
// default parameter values.
package cnn_pkg;

    localparam int unsigned FILTERNUM_WIDTH_DEF = 8;
    localparam int unsigned KERNELNUM_WIDTH_DEF = 8;
    localparam int unsigned DATANUM_WIDTH_DEF   = 8;
    localparam int unsigned TIMESTEP_WIDTH_DEF  = 8;
    localparam int unsigned STRIDE_WIDTH_DEF    = 4;
    localparam int unsigned ADDR_WIDTH_DEF      = 10;
    localparam int unsigned W_BASE_DEF          = 0;
    localparam int unsigned I_BASE_DEF          = 100;
    localparam int unsigned O_BASE_DEF          = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_I = 3'd2,
        CONV   = 3'd3,
        UPDATE = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear, enable and a
// terminal-count flag that compares against a caller-supplied limit.
module up_counter
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Clear has priority over increment; the count wraps, never saturates.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for a 1-D convolution engine: loads weights, loads an
// input window, runs the array, then writes one output per timestep while
// sliding the window by stride words.
module conv_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned FILTERNUM_WIDTH = FILTERNUM_WIDTH_DEF,
    parameter int unsigned KERNELNUM_WIDTH = KERNELNUM_WIDTH_DEF,
    parameter int unsigned DATANUM_WIDTH   = DATANUM_WIDTH_DEF,
    parameter int unsigned TIMESTEP_WIDTH  = TIMESTEP_WIDTH_DEF,
    parameter int unsigned STRIDE_WIDTH    = STRIDE_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int unsigned W_BASE          = W_BASE_DEF,
    parameter int unsigned I_BASE          = I_BASE_DEF,
    parameter int unsigned O_BASE          = O_BASE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stall,
    input  logic [FILTERNUM_WIDTH-1:0] num_filter,
    input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
    input  logic [DATANUM_WIDTH-1:0]   filter_length,
    input  logic [TIMESTEP_WIDTH-1:0]  num_total_conv,
    input  logic [STRIDE_WIDTH-1:0]    stride,
    output logic                       busy,
    output logic                       done,
    output logic                       filter_load,
    output logic                       input_load,
    output logic                       sys_start,
    output logic                       sum_timestep,
    output logic                       write_enable,
    output logic [ADDR_WIDTH-1:0]      data_addr,
    output logic [ADDR_WIDTH-1:0]      outmem_addr,
    output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
    output logic [KERNELNUM_WIDTH-1:0] kernel_cnt,
    output logic [DATANUM_WIDTH-1:0]   cal_cnt
);

    localparam logic [ADDR_WIDTH-1:0] W_BASE_A = ADDR_WIDTH'(W_BASE);
    localparam logic [ADDR_WIDTH-1:0] I_BASE_A = ADDR_WIDTH'(I_BASE);
    localparam logic [ADDR_WIDTH-1:0] O_BASE_A = ADDR_WIDTH'(O_BASE);

    state_t state, state_next;

    logic [FILTERNUM_WIDTH-1:0] nf_q;
    logic [KERNELNUM_WIDTH-1:0] nk_q;
    logic [DATANUM_WIDTH-1:0]   fl_q;
    logic [TIMESTEP_WIDTH-1:0]  ntc_q;
    logic [STRIDE_WIDTH-1:0]    stride_q;
    logic [ADDR_WIDTH-1:0]      in_ptr;
    logic                       first_load;
    logic [TIMESTEP_WIDTH-1:0]  conv_cnt;
    logic [KERNELNUM_WIDTH-1:0] load_len;
    logic                       go;
    logic                       filter_tc, kernel_tc, cal_tc, conv_tc;

    assign go = (state == IDLE) && start;

    // First window is num_kernel words; each later slide is stride words (0 acts as 1).
    assign load_len = first_load ? nk_q
                    : ((stride_q == '0) ? KERNELNUM_WIDTH'(1) : KERNELNUM_WIDTH'(stride_q));

    up_counter #(.WIDTH(FILTERNUM_WIDTH)) u_filter_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state == LOAD_W) && !stall),
        .clr   (go),
        .limit (nf_q - FILTERNUM_WIDTH'(1)),
        .count (filter_cnt),
        .tc    (filter_tc)
    );

    up_counter #(.WIDTH(KERNELNUM_WIDTH)) u_kernel_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state == LOAD_I) && !stall),
        .clr   (go || ((state != LOAD_I) && (state_next == LOAD_I))),
        .limit (load_len - KERNELNUM_WIDTH'(1)),
        .count (kernel_cnt),
        .tc    (kernel_tc)
    );

    up_counter #(.WIDTH(DATANUM_WIDTH)) u_cal_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state == CONV) && !stall),
        .clr   (go || ((state == UPDATE) && !stall)),
        .limit (fl_q),
        .count (cal_cnt),
        .tc    (cal_tc)
    );

    up_counter #(.WIDTH(TIMESTEP_WIDTH)) u_conv_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state == UPDATE) && !stall),
        .clr   (go),
        .limit (ntc_q - TIMESTEP_WIDTH'(1)),
        .count (conv_cnt),
        .tc    (conv_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the job configuration only when a job is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            nf_q     <= '0;
            nk_q     <= '0;
            fl_q     <= '0;
            ntc_q    <= '0;
            stride_q <= '0;
        end else if (go) begin
            nf_q     <= num_filter;
            nk_q     <= num_kernel;
            fl_q     <= filter_length;
            ntc_q    <= num_total_conv;
            stride_q <= stride;
        end
    end

    // Input read pointer runs continuously across windows; first_load marks the initial fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ptr     <= '0;
            first_load <= 1'b0;
        end else if (go) begin
            in_ptr     <= '0;
            first_load <= 1'b1;
        end else if ((state == LOAD_I) && !stall) begin
            in_ptr <= in_ptr + ADDR_WIDTH'(1);
            if (kernel_tc) begin
                first_load <= 1'b0;
            end
        end
    end

    // Next-state and output decode; strobes are masked by stall, addresses are not.
    always_comb begin
        state_next   = state;
        busy         = (state != IDLE);
        done         = 1'b0;
        filter_load  = 1'b0;
        input_load   = 1'b0;
        sys_start    = 1'b0;
        sum_timestep = 1'b0;
        write_enable = 1'b0;
        data_addr    = '0;
        outmem_addr  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((num_total_conv == '0) || (num_kernel == '0)) begin
                        state_next = DONE;
                    end else if (num_filter == '0) begin
                        state_next = LOAD_I;
                    end else begin
                        state_next = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                filter_load = !stall;
                data_addr   = W_BASE_A + ADDR_WIDTH'(filter_cnt);
                if (!stall && filter_tc) begin
                    state_next = LOAD_I;
                end
            end
            LOAD_I: begin
                input_load = !stall;
                data_addr  = I_BASE_A + in_ptr;
                if (!stall && kernel_tc) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                sys_start = !stall;
                if (!stall && cal_tc) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                sum_timestep = !stall;
                write_enable = !stall;
                outmem_addr  = O_BASE_A + ADDR_WIDTH'(conv_cnt);
                if (!stall) begin
                    state_next = conv_tc ? DONE : LOAD_I;
                end
            end
            DONE: begin
                done = !stall;
                if (!stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: every cycle of each job is checked
// against hand-derived strobe/address expectations.
module tb_conv_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, start_w, stall;
    logic [7:0] num_filter, num_kernel, filter_length, num_total_conv;
    logic [3:0] stride;

    logic       busy, done, filter_load, input_load, sys_start, sum_timestep, write_enable;
    logic [9:0] data_addr, outmem_addr;
    logic [7:0] filter_cnt, kernel_cnt, cal_cnt;

    logic       w_busy, w_done, w_filter_load, w_input_load, w_sys_start, w_sum_timestep, w_write_enable;
    logic [6:0] w_data_addr, w_outmem_addr;
    logic [7:0] w_filter_cnt, w_kernel_cnt, w_cal_cnt;

    int checks = 0;
    int errors = 0;

    // {busy, done, filter_load, input_load, sys_start, sum_timestep, write_enable}
    localparam logic [6:0] S_ID = 7'b0000000;
    localparam logic [6:0] S_LW = 7'b1010000;
    localparam logic [6:0] S_LI = 7'b1001000;
    localparam logic [6:0] S_CV = 7'b1000100;
    localparam logic [6:0] S_UP = 7'b1000011;
    localparam logic [6:0] S_DN = 7'b1100000;
    localparam logic [6:0] S_BZ = 7'b1000000;

    conv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .num_filter(num_filter), .num_kernel(num_kernel), .filter_length(filter_length),
        .num_total_conv(num_total_conv), .stride(stride),
        .busy(busy), .done(done), .filter_load(filter_load), .input_load(input_load),
        .sys_start(sys_start), .sum_timestep(sum_timestep), .write_enable(write_enable),
        .data_addr(data_addr), .outmem_addr(outmem_addr),
        .filter_cnt(filter_cnt), .kernel_cnt(kernel_cnt), .cal_cnt(cal_cnt)
    );

    conv_sequencer #(.ADDR_WIDTH(7), .I_BASE(120)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .stall(stall),
        .num_filter(num_filter), .num_kernel(num_kernel), .filter_length(filter_length),
        .num_total_conv(num_total_conv), .stride(stride),
        .busy(w_busy), .done(w_done), .filter_load(w_filter_load), .input_load(w_input_load),
        .sys_start(w_sys_start), .sum_timestep(w_sum_timestep), .write_enable(w_write_enable),
        .data_addr(w_data_addr), .outmem_addr(w_outmem_addr),
        .filter_cnt(w_filter_cnt), .kernel_cnt(w_kernel_cnt), .cal_cnt(w_cal_cnt)
    );

    function automatic logic [6:0] strobes();
        return {busy, done, filter_load, input_load, sys_start, sum_timestep, write_enable};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic cfg(input int nf, input int nk, input int fl, input int ntc, input int s);
        num_filter     = 8'(nf);
        num_kernel     = 8'(nk);
        filter_length  = 8'(fl);
        num_total_conv = 8'(ntc);
        stride         = 4'(s);
    endtask

    task automatic cyc(input string tag, input logic [6:0] s, input int da, input int oa);
        #1;
        chk({tag, "_strobes"}, 32'(strobes()), 32'(s));
        chk({tag, "_data_addr"}, 32'(data_addr), 32'(da));
        chk({tag, "_outmem_addr"}, 32'(outmem_addr), 32'(oa));
        tick();
    endtask

    task automatic loadw(input int f0, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("loadw_filter_cnt", 32'(filter_cnt), 32'(f0 + i));
            cyc("loadw", S_LW, f0 + i, 0);
        end
    endtask

    task automatic loadi(input int a0, input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("loadi_kernel_cnt", 32'(kernel_cnt), 32'(k0 + i));
            cyc("loadi", S_LI, a0 + i, 0);
        end
    endtask

    task automatic conv(input int c0, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("conv_cal_cnt", 32'(cal_cnt), 32'(c0 + i));
            cyc("conv", S_CV, 0, 0);
        end
    endtask

    task automatic update(input int o);
        cyc("update", S_UP, 0, o);
    endtask

    task automatic run_nominal(input bit poke);
        cfg(4, 8, 3, 3, 2);
        start = 1'b1;
        cyc("idle_start", S_ID, 0, 0);
        loadw(0, 2);
        if (poke) begin
            start = 1'b1;
            cfg(1, 1, 0, 1, 1);
        end
        loadw(2, 2);
        loadi(100, 0, 8); conv(0, 4); update(0);
        loadi(108, 0, 2); conv(0, 4); update(1);
        loadi(110, 0, 2); conv(0, 4); update(2);
        if (poke) start = 1'b1;
        cyc("done", S_DN, 0, 0);
        #1;
        chk("idle_filter_cnt", 32'(filter_cnt), 32'd4);
        cyc("idle", S_ID, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_w = 1'b0; stall = 1'b0;
        cfg(0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;

        // Reset state.
        #1;
        chk("rst_strobes", 32'(strobes()), 32'(S_ID));
        chk("rst_data_addr", 32'(data_addr), 32'd0);
        chk("rst_outmem_addr", 32'(outmem_addr), 32'd0);
        chk("rst_filter_cnt", 32'(filter_cnt), 32'd0);
        chk("rst_kernel_cnt", 32'(kernel_cnt), 32'd0);
        chk("rst_cal_cnt", 32'(cal_cnt), 32'd0);
        tick();

        // Nominal job.
        run_nominal(1'b0);

        // Stall: 3 cycles mid-LOAD_I, 2 cycles mid-CONV.
        cfg(4, 8, 3, 3, 2);
        start = 1'b1;
        tick();
        loadw(0, 4);
        loadi(100, 0, 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_li_kernel_cnt", 32'(kernel_cnt), 32'd3);
            cyc("stall_li", S_BZ, 103, 0);
        end
        stall = 1'b0;
        loadi(103, 3, 5);
        conv(0, 2);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_cv_cal_cnt", 32'(cal_cnt), 32'd2);
            cyc("stall_cv", S_BZ, 0, 0);
        end
        stall = 1'b0;
        conv(2, 2); update(0);
        loadi(108, 0, 2); conv(0, 4); update(1);
        loadi(110, 0, 2); conv(0, 4); update(2);
        cyc("stall_done", S_DN, 0, 0);
        cyc("stall_idle", S_ID, 0, 0);

        // num_total_conv = 0 and num_kernel = 0 go straight to DONE.
        cfg(4, 8, 3, 0, 2);
        start = 1'b1;
        cyc("z_ntc_start", S_ID, 0, 0);
        cyc("z_ntc_done", S_DN, 0, 0);
        cyc("z_ntc_idle", S_ID, 0, 0);
        cfg(4, 0, 3, 3, 2);
        start = 1'b1;
        cyc("z_nk_start", S_ID, 0, 0);
        cyc("z_nk_done", S_DN, 0, 0);
        cyc("z_nk_idle", S_ID, 0, 0);

        // num_filter = 0 skips LOAD_W; stall alongside start does not block the exit.
        cfg(0, 2, 1, 1, 1);
        start = 1'b1;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        loadi(100, 0, 2);
        conv(0, 2);
        #1;
        chk("nf0_filter_cnt", 32'(filter_cnt), 32'd0);
        update(0);
        cyc("nf0_done", S_DN, 0, 0);
        cyc("nf0_idle", S_ID, 0, 0);

        // Stride 0 behaves as stride 1.
        cfg(0, 1, 0, 2, 0);
        start = 1'b1;
        tick();
        loadi(100, 0, 1); conv(0, 1); update(0);
        loadi(101, 0, 1); conv(0, 1); update(1);
        cyc("s0_done", S_DN, 0, 0);
        cyc("s0_idle", S_ID, 0, 0);

        // Reset mid-CONV, then a clean rerun.
        cfg(4, 8, 3, 3, 2);
        start = 1'b1;
        tick();
        loadw(0, 4);
        loadi(100, 0, 8);
        conv(0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_strobes", 32'(strobes()), 32'(S_ID));
        chk("midrst_data_addr", 32'(data_addr), 32'd0);
        chk("midrst_outmem_addr", 32'(outmem_addr), 32'd0);
        chk("midrst_filter_cnt", 32'(filter_cnt), 32'd0);
        chk("midrst_kernel_cnt", 32'(kernel_cnt), 32'd0);
        chk("midrst_cal_cnt", 32'(cal_cnt), 32'd0);
        tick();
        run_nominal(1'b0);

        // start pulsed while busy (LOAD_W and DONE) with different config applied.
        run_nominal(1'b1);

        // Address wrap on the 7-bit instance starting at 120.
        cfg(0, 12, 0, 1, 1);
        start_w = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("wrap_input_load", 32'(w_input_load), 32'd1);
            chk("wrap_data_addr", 32'(w_data_addr), 32'((120 + i) % 128));
            tick();
        end
        #1;
        chk("wrap_sys_start", 32'(w_sys_start), 32'd1);
        tick();
        #1;
        chk("wrap_write_enable", 32'(w_write_enable), 32'd1);
        chk("wrap_outmem_addr", 32'(w_outmem_addr), 32'd0);
        tick();
        #1;
        chk("wrap_done", 32'(w_done), 32'd1);
        tick();
        #1;
        chk("wrap_idle_busy", 32'(w_busy), 32'd0);
        chk("main_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
